lap_recall: RTL and testbench

Lap-time capture and recall stage between `stopwatch_logic` and `display_driver`. It records up to `DEPTH` snapshots of the running time on lap presses. On recall presses it replaces the live time on the display path with stored laps, newest first, and returns to live view on timeout or after the oldest lap. Time fields are carried as opaque 8-bit values; no arithmetic is performed on them.

---
 rtl/lap_recall_if.sv | 33 +++
 rtl/lap_recall.sv | 170 +++++++++++++++++
 tb/tb_lap_recall.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lap_recall_if.sv
// Bundle of button, tick and time signals between the stopwatch core,
// the lap recall stage and the display driver.
interface lap_recall_if;
  logic       tick;
  logic       lap;
  logic       recall;
  logic       clear;
  logic [7:0] hours_in;
  logic [7:0] minutes_in;
  logic [7:0] seconds_in;
  logic [7:0] centisec_in;
  logic [7:0] hours_out;
  logic [7:0] minutes_out;
  logic [7:0] seconds_out;
  logic [7:0] centisec_out;
  logic       recall_active;
  logic [4:0] lap_index;
  logic [4:0] lap_count;

  modport master (
    output tick, lap, recall, clear,
    output hours_in, minutes_in, seconds_in, centisec_in,
    input  hours_out, minutes_out, seconds_out, centisec_out,
    input  recall_active, lap_index, lap_count
  );

  modport slave (
    input  tick, lap, recall, clear,
    input  hours_in, minutes_in, seconds_in, centisec_in,
    output hours_out, minutes_out, seconds_out, centisec_out,
    output recall_active, lap_index, lap_count
  );
endinterface

// File: rtl/lap_recall.sv
// Lap-time capture and recall between the stopwatch core and the display driver.
// Stores up to DEPTH time snapshots and replays them newest first on recall presses.
module lap_recall #(
  parameter int DEPTH         = 8,
  parameter int TIMEOUT_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  lap_recall_if.slave bus
);
  // state  | meaning
  // LIVE   | display follows live time; lap presses record snapshots
  // RECALL | display shows mem[rd_ptr]; inactivity timeout armed

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [4:0]       CNT_FULL = 5'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_TICKS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(1);

  typedef enum logic {LIVE, RECALL} state_t;

  logic [2:0] btn_meta;
  logic [2:0] btn_sync;
  logic [2:0] btn_hist;
  logic [2:0] btn_press;
  logic       press_lap;
  logic       press_recall;
  logic       press_clear;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] prev_wr;
  logic [PTR_W-1:0] prev_rd;
  logic [TMR_W-1:0] tmr;
  logic [4:0]       cnt;
  logic [4:0]       idx;
  logic             active;
  logic [31:0]      disp;
  logic [31:0]      live_time;
  logic             mem_we;
  logic [31:0]      mem [DEPTH];

  // Flops preset to 1 so a button held through reset release is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= '1;
      btn_sync <= '1;
      btn_hist <= '1;
    end else begin
      btn_meta <= {bus.clear, bus.recall, bus.lap};
      btn_sync <= btn_meta;
      btn_hist <= btn_sync;
    end
  end

  assign btn_press    = btn_sync & ~btn_hist;
  assign press_lap    = btn_press[0];
  assign press_recall = btn_press[1];
  assign press_clear  = btn_press[2];

  assign live_time = {bus.hours_in, bus.minutes_in, bus.seconds_in, bus.centisec_in};
  assign prev_wr   = wr_ptr - 1'b1;
  assign prev_rd   = rd_ptr - 1'b1;

  // The snapshot is what LIVE is displaying right now, i.e. the registered inputs.
  assign mem_we = (state == LIVE) && press_lap && !press_clear;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= disp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LIVE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tmr    <= '0;
      cnt    <= '0;
      idx    <= '0;
      active <= 1'b0;
      disp   <= '0;
    end else if (press_clear) begin
      state  <= LIVE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tmr    <= '0;
      cnt    <= '0;
      idx    <= '0;
      active <= 1'b0;
      disp   <= live_time;
    end else begin
      case (state)
        LIVE: begin
          disp   <= live_time;
          active <= 1'b0;
          idx    <= '0;
          tmr    <= '0;
          if (press_lap) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (cnt != CNT_FULL) begin
              cnt <= cnt + 5'd1;
            end
          end else if (press_recall && (cnt != 5'd0)) begin
            state  <= RECALL;
            rd_ptr <= prev_wr;
            idx    <= cnt;
            active <= 1'b1;
            disp   <= mem[prev_wr];
            tmr    <= TMR_LOAD;
          end
        end

        RECALL: begin
          if (press_lap) begin
            state  <= LIVE;
            disp   <= live_time;
            active <= 1'b0;
            idx    <= '0;
            tmr    <= '0;
          end else if (press_recall) begin
            if (idx > 5'd1) begin
              rd_ptr <= prev_rd;
              idx    <= idx - 5'd1;
              disp   <= mem[prev_rd];
              tmr    <= TMR_LOAD;
            end else begin
              state  <= LIVE;
              disp   <= live_time;
              active <= 1'b0;
              idx    <= '0;
              tmr    <= '0;
            end
          end else if (bus.tick && (tmr == TMR_LAST)) begin
            // Down-counter terminal count: this tick is the TIMEOUT_TICKS-th.
            state  <= LIVE;
            disp   <= live_time;
            active <= 1'b0;
            idx    <= '0;
            tmr    <= '0;
          end else begin
            disp <= mem[rd_ptr];
            if (bus.tick) begin
              tmr <= tmr - 1'b1;
            end
          end
        end

        default: begin
          state  <= LIVE;
          disp   <= live_time;
          active <= 1'b0;
          idx    <= '0;
          tmr    <= '0;
        end
      endcase
    end
  end

  assign bus.hours_out     = disp[31:24];
  assign bus.minutes_out   = disp[23:16];
  assign bus.seconds_out   = disp[15:8];
  assign bus.centisec_out  = disp[7:0];
  assign bus.recall_active = active;
  assign bus.lap_index     = idx;
  assign bus.lap_count     = cnt;
endmodule

// File: tb/tb_lap_recall.sv
// Bench for lap_recall: directed vector table, timeout/reset sequences and
// randomized traffic checked every cycle against a queue-based lap model.
module tb_lap_recall;
  localparam int DEPTH         = 8;
  localparam int TIMEOUT_TICKS = 500;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lap_recall_if bus();

  lap_recall #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: stored laps oldest first, view = displayed 1-based lap (0 = live).
  logic [31:0] m_laps[$];
  int          m_view;
  int          m_quiet;
  logic [3:0]  m_samp [3];
  logic [31:0] m_prev_in;
  logic [31:0] m_exp_out;

  typedef struct {
    logic [2:0] btn;      // {clear, recall, lap}
    logic [7:0] cs;
    logic [7:0] exp_cs;
    logic [4:0] exp_idx;
    logic [4:0] exp_cnt;
    logic       exp_act;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] live_in();
    return {bus.hours_in, bus.minutes_in, bus.seconds_in, bus.centisec_in};
  endfunction

  function automatic logic [63:0] dut_state();
    return {21'd0, bus.hours_out, bus.minutes_out, bus.seconds_out, bus.centisec_out,
            bus.recall_active, bus.lap_index, bus.lap_count};
  endfunction

  function automatic logic [63:0] model_state();
    return {21'd0, m_exp_out, (m_view != 0), 5'(m_view), 5'(m_laps.size())};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_laps.delete();
    m_view    = 0;
    m_quiet   = 0;
    for (int i = 0; i < 3; i++) m_samp[i] = 4'hF;
    m_prev_in = '0;
    m_exp_out = '0;
  endtask

  task automatic model_edge();
    logic [2:0] b;
    logic [2:0] p;
    b = {bus.clear, bus.recall, bus.lap};
    // a press commits two edges after the level is first sampled high
    for (int i = 0; i < 3; i++) begin
      m_samp[i] = {m_samp[i][2:0], b[i]};
      p[i] = m_samp[i][2] & ~m_samp[i][3];
    end
    if (p[2]) begin
      m_laps.delete();
      m_view  = 0;
      m_quiet = 0;
    end else if (m_view == 0) begin
      if (p[0]) begin
        if (m_laps.size() == DEPTH) void'(m_laps.pop_front());
        m_laps.push_back(m_prev_in);
      end else if (p[1] && m_laps.size() > 0) begin
        m_view  = m_laps.size();
        m_quiet = 0;
      end
    end else begin
      if (p[0]) m_view = 0;
      else if (p[1]) begin
        m_view--;
        m_quiet = 0;
      end else if (bus.tick) begin
        m_quiet++;
        if (m_quiet == TIMEOUT_TICKS) m_view = 0;
      end
    end
    m_exp_out = (m_view == 0) ? live_in() : m_laps[m_view-1];
    m_prev_in = live_in();
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    chk("cycle", dut_state(), model_state());
  endtask

  task automatic press(input logic [2:0] btn, input logic [7:0] cs);
    bus.centisec_in = cs;
    step();
    step();
    {bus.clear, bus.recall, bus.lap} = btn;
    step();
    step();
    step();
  endtask

  task automatic release_btns();
    {bus.clear, bus.recall, bus.lap} = 3'b000;
    step();
    step();
  endtask

  task automatic press_rel(input logic [2:0] btn, input logic [7:0] cs);
    press(btn, cs);
    release_btns();
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step();
  endtask

  task automatic chk_view(input string name, input logic [7:0] cs, input logic [4:0] i,
                          input logic [4:0] c, input logic a);
    chk(name, {bus.centisec_out, bus.lap_index, bus.lap_count, bus.recall_active},
        {cs, i, c, a});
  endtask

  initial begin
    vecs[0]  = '{3'b001, 8'h11, 8'h11, 5'd0, 5'd1, 1'b0};
    vecs[1]  = '{3'b001, 8'h22, 8'h22, 5'd0, 5'd2, 1'b0};
    vecs[2]  = '{3'b001, 8'h33, 8'h33, 5'd0, 5'd3, 1'b0};
    vecs[3]  = '{3'b010, 8'h44, 8'h33, 5'd3, 5'd3, 1'b1};
    vecs[4]  = '{3'b010, 8'h44, 8'h22, 5'd2, 5'd3, 1'b1};
    vecs[5]  = '{3'b010, 8'h44, 8'h11, 5'd1, 5'd3, 1'b1};
    vecs[6]  = '{3'b010, 8'h44, 8'h44, 5'd0, 5'd3, 1'b0};
    vecs[7]  = '{3'b011, 8'h55, 8'h55, 5'd0, 5'd4, 1'b0};
    vecs[8]  = '{3'b010, 8'h55, 8'h55, 5'd4, 5'd4, 1'b1};
    vecs[9]  = '{3'b001, 8'h66, 8'h66, 5'd0, 5'd4, 1'b0};
    vecs[10] = '{3'b101, 8'h77, 8'h77, 5'd0, 5'd0, 1'b0};
    vecs[11] = '{3'b010, 8'h77, 8'h77, 5'd0, 5'd0, 1'b0};

    // reset with lap held through release
    bus.tick = 1'b0; bus.lap = 1'b1; bus.recall = 1'b0; bus.clear = 1'b0;
    bus.hours_in = 8'h12; bus.minutes_in = 8'h34; bus.seconds_in = 8'h56; bus.centisec_in = 8'h78;
    rst = 1'b1;
    model_reset();
    #3;
    chk("reset_state", dut_state(), 64'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("held_lap_no_press", {59'd0, bus.lap_count}, 64'd0);
    chk("live_track", {32'd0, bus.hours_out, bus.minutes_out, bus.seconds_out, bus.centisec_out},
        64'h12345678);
    bus.lap = 1'b0;
    bus.hours_in = 8'h00; bus.minutes_in = 8'h00; bus.seconds_in = 8'h00;
    step();
    step();

    for (int i = 0; i < 12; i++) begin
      press(vecs[i].btn, vecs[i].cs);
      chk_view($sformatf("vec%0d", i), vecs[i].exp_cs, vecs[i].exp_idx, vecs[i].exp_cnt,
               vecs[i].exp_act);
      release_btns();
    end

    // overflow: 10 laps into 8 slots, walk newest to oldest
    for (int i = 1; i <= 10; i++) press_rel(3'b001, 8'(i));
    chk("overflow_count", {59'd0, bus.lap_count}, 64'd8);
    for (int k = 0; k < 8; k++) begin
      press(3'b010, 8'hEE);
      chk_view($sformatf("walk%0d", k), 8'(10 - k), 5'(8 - k), 5'd8, 1'b1);
      release_btns();
    end
    press(3'b010, 8'hEE);
    chk_view("walk_exit", 8'hEE, 5'd0, 5'd8, 1'b0);
    release_btns();

    // timeout: restart on recall step, exit on the TIMEOUT_TICKS-th tick
    press_rel(3'b100, 8'h00);
    press_rel(3'b001, 8'hA1);
    press_rel(3'b001, 8'hA2);
    press_rel(3'b010, 8'h00);
    for (int i = 0; i < 299; i++) tick_pulse();
    chk_view("to_before_step", 8'hA2, 5'd2, 5'd2, 1'b1);
    press_rel(3'b010, 8'h00);
    for (int i = 0; i < TIMEOUT_TICKS - 1; i++) tick_pulse();
    chk_view("to_499", 8'hA1, 5'd1, 5'd2, 1'b1);
    tick_pulse();
    chk_view("to_500", 8'h00, 5'd0, 5'd2, 1'b0);

    // recall press on the same edge as the final tick wins
    press_rel(3'b010, 8'h00);
    for (int i = 0; i < TIMEOUT_TICKS - 1; i++) tick_pulse();
    bus.recall = 1'b1;
    step();
    step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    chk_view("tick_vs_recall", 8'hA1, 5'd1, 5'd2, 1'b1);
    release_btns();
    for (int i = 0; i < TIMEOUT_TICKS - 1; i++) tick_pulse();
    chk_view("restart_499", 8'hA1, 5'd1, 5'd2, 1'b1);
    tick_pulse();
    chk_view("restart_500", 8'h00, 5'd0, 5'd2, 1'b0);

    // asynchronous reset mid-recall
    press_rel(3'b010, 8'h00);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst", dut_state(), 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // random traffic: dense buttons
    for (int n = 0; n < 3000; n++) begin
      int r;
      bus.hours_in = 8'($urandom); bus.minutes_in = 8'($urandom);
      bus.seconds_in = 8'($urandom); bus.centisec_in = 8'($urandom);
      bus.tick = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 31);
      if (r < 3) bus.lap = ~bus.lap;
      else if (r < 6) bus.recall = ~bus.recall;
      else if (r == 6) bus.clear = ~bus.clear;
      step();
    end
    bus.tick = 1'b0;
    release_btns();
    for (int i = 0; i < 3; i++) press_rel(3'b001, 8'($urandom));

    // random traffic: frequent ticks, sparse recall to reach timeouts
    for (int n = 0; n < 4000; n++) begin
      bus.hours_in = 8'($urandom); bus.minutes_in = 8'($urandom);
      bus.seconds_in = 8'($urandom); bus.centisec_in = 8'($urandom);
      bus.tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) bus.recall = ~bus.recall;
      if ($urandom_range(0, 1499) == 0) bus.lap = ~bus.lap;
      step();
    end
    bus.tick = 1'b0;
    release_btns();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
